// File: rtl/gv_slot_pkg.sv
// gv_slot_pkg: slot state encoding and bank-count legality helpers
package gv_slot_pkg;
  typedef enum logic [1:0] {FREE, INIT, ARMED, RUN} slot_state_e;
  localparam int MIN_BANK_COUNT = 4;
  localparam int MAX_BANK_COUNT = 8;
  function automatic bit bank_legal(input int banks);
    return banks == MIN_BANK_COUNT || banks == MAX_BANK_COUNT;
  endfunction
endpackage

// File: rtl/slot_ctx.sv
// slot_ctx: per-slot lifecycle fsm holding beat count and tag
module slot_ctx
  import gv_slot_pkg::*;
#(
  parameter int VL_W  = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             alloc,
  input  logic             turn,
  input  logic [VL_W-1:0]  vlm1,
  input  logic [TAG_W-1:0] tag_in,
  output slot_state_e      state,
  output logic [TAG_W-1:0] tag,
  output logic             fire,
  output logic             last
);
  slot_state_e      state_q, state_d;
  logic [VL_W-1:0]  rem_q, rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  always_comb begin
    fire    = (state_q == ARMED || state_q == RUN) && turn && !stall;
    last    = rem_q == '0;
    state_d = alloc ? INIT
            : (state_q == INIT && !stall) ? ARMED
            : fire ? (last ? FREE : RUN)
            : state_q;
    rem_d   = alloc ? vlm1 : (fire && !last) ? rem_q - 1'b1 : rem_q;
    tag_d   = alloc ? tag_in : tag_q;
    state   = state_q;
    tag     = tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      rem_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: rtl/slot_allocator.sv
// slot_allocator: binds vector ops to free slots and issues one beat per counter turn
module slot_allocator
  import gv_slot_pkg::*;
#(
  parameter int  BANK_COUNT = 4,
  localparam int SLOT_COUNT = BANK_COUNT / 2,
  localparam int IDX_W      = $clog2(SLOT_COUNT),
  parameter int  VL_W       = 8,
  parameter int  TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VL_W-1:0]       in_vlm1,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [SLOT_COUNT-1:0] slot_turn,
  output logic [SLOT_COUNT-1:0] slot_init,
  output logic [SLOT_COUNT-1:0] slot_active,
  output logic                  issue_valid,
  output logic [IDX_W-1:0]      issue_slot,
  output logic [TAG_W-1:0]      issue_tag,
  output logic                  issue_last,
  output logic                  done_valid,
  output logic [TAG_W-1:0]      done_tag
);
  slot_state_e             state [SLOT_COUNT];
  logic [TAG_W-1:0]        tags  [SLOT_COUNT];
  logic [SLOT_COUNT-1:0]   free, alloc, fire, last;
  logic                    accept;
  logic [IDX_W-1:0]        fire_idx;
  logic                    issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]        issue_slot_q, issue_slot_d;
  logic [TAG_W-1:0]        issue_tag_q, issue_tag_d;
  logic                    issue_last_q, issue_last_d;
  logic                    done_valid_q, done_valid_d;
  logic [TAG_W-1:0]        done_tag_q, done_tag_d;
  for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_slot
    slot_ctx #(.VL_W(VL_W), .TAG_W(TAG_W)) u_ctx (
      .clk    (clk),
      .rst    (rst),
      .stall  (stall),
      .alloc  (alloc[i]),
      .turn   (slot_turn[i]),
      .vlm1   (in_vlm1),
      .tag_in (in_tag),
      .state  (state[i]),
      .tag    (tags[i]),
      .fire   (fire[i]),
      .last   (last[i])
    );
    always_comb begin
      free[i]        = state[i] == FREE;
      slot_init[i]   = state[i] == INIT;
      slot_active[i] = state[i] == ARMED || state[i] == RUN;
    end
  end
  always_comb begin
    in_ready = |free && !stall;
    accept   = in_valid && in_ready;
    alloc    = accept ? free & (~free + SLOT_COUNT'(1)) : '0;
    fire_idx = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) if (fire[i]) fire_idx = IDX_W'(i);
    issue_valid_d = |fire;
    issue_slot_d  = fire_idx;
    issue_tag_d   = |fire ? tags[fire_idx] : '0;
    issue_last_d  = |fire && last[fire_idx];
    done_valid_d  = issue_last_d;
    done_tag_d    = issue_last_d ? tags[fire_idx] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_slot_q  <= '0;
      issue_tag_q   <= '0;
      issue_last_q  <= 1'b0;
      done_valid_q  <= 1'b0;
      done_tag_q    <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_slot_q  <= issue_slot_d;
      issue_tag_q   <= issue_tag_d;
      issue_last_q  <= issue_last_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
    end
  end
  always_comb begin
    issue_valid = issue_valid_q;
    issue_slot  = issue_slot_q;
    issue_tag   = issue_tag_q;
    issue_last  = issue_last_q;
    done_valid  = done_valid_q;
    done_tag    = done_tag_q;
  end
  a_bank_legal: assert property (@(posedge clk) bank_legal(BANK_COUNT));
  a_turn_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_turn));
  a_init_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_init));
  a_alloc_free: assert property (@(posedge clk) disable iff (rst) (alloc & ~free) == '0);
endmodule

// File: tb/tb_slot_allocator.sv
// tb_slot_allocator: random and directed stimulus against a beat-count reference model
module tb_slot_allocator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_vlm1 = '0;
  logic [3:0] in_tag = '0;
  logic [1:0] slot_turn = '0;
  logic [1:0] slot_init, slot_active;
  logic       issue_valid, issue_last, done_valid;
  logic [0:0] issue_slot;
  logic [3:0] issue_tag, done_tag;
  int n_chk = 0;
  int n_fail = 0;
  bit occ [2];
  bit ini [2];
  int left [2];
  int mtag [2];
  bit e_iv, e_il, e_dv;
  int e_is, e_it, e_dt;
  slot_allocator #(.BANK_COUNT(4), .VL_W(8), .TAG_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vlm1     (in_vlm1),
    .in_tag      (in_tag),
    .slot_turn   (slot_turn),
    .slot_init   (slot_init),
    .slot_active (slot_active),
    .issue_valid (issue_valid),
    .issue_slot  (issue_slot),
    .issue_tag   (issue_tag),
    .issue_last  (issue_last),
    .done_valid  (done_valid),
    .done_tag    (done_tag)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    stall = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      occ[s] = 0;
      ini[s] = 0;
      left[s] = 0;
      mtag[s] = 0;
    end
    e_iv = 0; e_il = 0; e_dv = 0; e_is = 0; e_it = 0; e_dt = 0;
  endtask
  task automatic cyc(input bit v, input int vl, input int tg, input bit [1:0] tr, input bit st);
    bit fr [2];
    bit er;
    bit [1:0] ei, ea;
    int pick;
    in_valid = v;
    in_vlm1 = 8'(vl);
    in_tag = 4'(tg);
    slot_turn = tr;
    stall = st;
    #1;
    er = !st && (!occ[0] || !occ[1]);
    for (int s = 0; s < 2; s++) begin
      ei[s] = occ[s] && ini[s];
      ea[s] = occ[s] && !ini[s];
      fr[s] = !occ[s];
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("slot_init", 32'(slot_init), 32'(ei));
    chk("slot_active", 32'(slot_active), 32'(ea));
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("done_valid", 32'(done_valid), 32'(e_dv));
    if (e_iv) begin
      chk("issue_slot", 32'(issue_slot), e_is);
      chk("issue_tag", 32'(issue_tag), e_it);
      chk("issue_last", 32'(issue_last), 32'(e_il));
    end
    if (e_dv) chk("done_tag", 32'(done_tag), e_dt);
    e_iv = 0; e_il = 0; e_dv = 0; e_is = 0; e_it = 0; e_dt = 0;
    if (!st) begin
      for (int s = 0; s < 2; s++) begin
        if (tr[s] && occ[s] && !ini[s]) begin
          left[s]--;
          e_iv = 1;
          e_is = s;
          e_it = mtag[s];
          e_il = left[s] == 0;
          if (e_il) begin
            occ[s] = 0;
            e_dv = 1;
            e_dt = mtag[s];
          end
        end
      end
      for (int s = 0; s < 2; s++) ini[s] = 0;
    end
    if (v && er) begin
      pick = fr[0] ? 0 : 1;
      occ[pick] = 1;
      ini[pick] = 1;
      left[pick] = vl + 1;
      mtag[pick] = tg;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bit [1:0] tr;
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 2'b00, 0);
    cyc(1, 3, 5, 2'b00, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, (k % 2) ? 2'b01 : 2'b10, 0);
    cyc(1, 1, 1, 2'b00, 0);
    cyc(1, 2, 2, 2'b00, 0);
    cyc(1, 7, 3, 2'b00, 0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, (k % 3 == 0) ? 2'b00 : (k % 3 == 1) ? 2'b10 : 2'b01, 0);
    cyc(1, 6, 4, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 2'b01, 0);
    for (int k = 0; k < 5; k++) cyc(1, 2, 8, 2'b01, 1);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 2'b01, 0);
    do_reset();
    cyc(1, 20, 6, 2'b00, 0);
    cyc(1, 20, 7, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 2'b10, 0);
    cyc(0, 0, 0, 2'b01, 0);
    slot_turn = 2'b10;
    do_reset();
    cyc(1, 0, 9, 2'b00, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 2'b01, 0);
    cyc(1, 0, 10, 2'b00, 0);
    cyc(1, 9, 11, 2'b00, 0);
    cyc(1, 4, 12, 2'b01, 0);
    cyc(1, 4, 12, 2'b00, 0);
    for (int k = 0; k < 30; k++) cyc(0, 0, 0, (k % 2) ? 2'b01 : 2'b10, 0);
    cyc(1, 255, 13, 2'b00, 0);
    for (int k = 0; k < 262; k++) cyc(0, 0, 0, 2'b01, 0);
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 2))
        0: tr = 2'b00;
        1: tr = 2'b01;
        default: tr = 2'b10;
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc(bit'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5)),
          int'($urandom_range(0, 15)), tr, $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
